am_env_ctrl: RTL and testbench



---
 rtl/am_env_pkg.sv | 30 +++
 rtl/am_env_cfg_regs.sv | 75 +++++++
 rtl/am_env_ctrl.sv | 117 +++++++++++
 tb/tb_am_env_ctrl.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/am_env_pkg.sv
// rtl/am_env_pkg.sv - shared types and constants for the AM envelope controller
// Loop support is enabled by defining AM_ENV_LOOP_EN.
package am_env_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ATTACK,
    ST_HOLD,
    ST_RELEASE
  } env_state_t;

  localparam logic [2:0] ADDR_ATTACK  = 3'd0;
  localparam logic [2:0] ADDR_RELEASE = 3'd1;
  localparam logic [2:0] ADDR_HOLD    = 3'd2;
  localparam logic [2:0] ADDR_LEVEL   = 3'd3;
  localparam logic [2:0] ADDR_LOOP    = 3'd4;

  localparam logic [15:0] ENV_ONE = 16'h8000;

  localparam logic [15:0] RST_ATTACK_STEP  = 16'h0100;
  localparam logic [15:0] RST_RELEASE_STEP = 16'h0100;
  localparam logic [15:0] RST_HOLD_LEN     = 16'h0000;
  localparam logic [15:0] RST_LEVEL        = ENV_ONE;
  localparam logic        RST_LOOP         = 1'b0;

  function automatic logic [15:0] clamp_level(input logic [15:0] value);
    return (value > ENV_ONE) ? ENV_ONE : value;
  endfunction

endpackage

// File: rtl/am_env_cfg_regs.sv
// rtl/am_env_cfg_regs.sv - envelope config register file with shadow copies latched on start
// The loop register at ADDR_LOOP exists only when AM_ENV_LOOP_EN is defined.
module am_env_cfg_regs
  import am_env_pkg::*;
#(
  parameter int HOLD_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [2:0]        cfg_addr,
  input  logic [15:0]       cfg_wdata,
  input  logic              load,
  output logic [15:0]       attack_step,
  output logic [15:0]       release_step,
  output logic [HOLD_W-1:0] hold_len,
  output logic [15:0]       level,
  output logic              loop
);

  logic [15:0]       attack_reg;
  logic [15:0]       release_reg;
  logic [HOLD_W-1:0] hold_reg;
  logic [15:0]       level_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      attack_reg   <= RST_ATTACK_STEP;
      release_reg  <= RST_RELEASE_STEP;
      hold_reg     <= HOLD_W'(RST_HOLD_LEN);
      level_reg    <= RST_LEVEL;
      attack_step  <= RST_ATTACK_STEP;
      release_step <= RST_RELEASE_STEP;
      hold_len     <= HOLD_W'(RST_HOLD_LEN);
      level        <= RST_LEVEL;
    end else begin
      if (cfg_we) begin
        case (cfg_addr)
          ADDR_ATTACK:  attack_reg  <= cfg_wdata;
          ADDR_RELEASE: release_reg <= cfg_wdata;
          ADDR_HOLD:    hold_reg    <= HOLD_W'(cfg_wdata);
          ADDR_LEVEL:   level_reg   <= clamp_level(cfg_wdata);
          default:      ;
        endcase
      end
      // Shadows take the register contents as of before any same-cycle write.
      if (load) begin
        attack_step  <= attack_reg;
        release_step <= release_reg;
        hold_len     <= hold_reg;
        level        <= level_reg;
      end
    end
  end

`ifdef AM_ENV_LOOP_EN
  logic loop_reg;
  logic loop_sh;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      loop_reg <= RST_LOOP;
      loop_sh  <= RST_LOOP;
    end else begin
      if (cfg_we && cfg_addr == ADDR_LOOP) loop_reg <= cfg_wdata[0];
      if (load) loop_sh <= loop_reg;
    end
  end

  assign loop = loop_sh;
`else
  assign loop = 1'b0;
`endif

endmodule

// File: rtl/am_env_ctrl.sv
// rtl/am_env_ctrl.sv - attack/hold/release envelope sequencer driving the AM modulator
// Optional looping of the envelope is enabled by defining AM_ENV_LOOP_EN.
module am_env_ctrl
  import am_env_pkg::*;
#(
  parameter int HOLD_W = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_sample_en,
  input  logic        i_start,
  input  logic        i_stop,
  input  logic        i_cfg_we,
  input  logic [2:0]  i_cfg_addr,
  input  logic [15:0] i_cfg_wdata,
  output logic [15:0] o_env_q15,
  output logic        o_mod_enable,
  output logic        o_busy,
  output logic        o_done
);

  env_state_t        state;
  logic [HOLD_W-1:0] hold_cnt;
  logic              loop_run;

  logic [15:0]       sh_attack;
  logic [15:0]       sh_release;
  logic [HOLD_W-1:0] sh_hold;
  logic [15:0]       sh_level;
  logic              sh_loop;

  am_env_cfg_regs #(
    .HOLD_W(HOLD_W)
  ) u_cfg (
    .clk         (clk),
    .rst         (rst),
    .cfg_we      (i_cfg_we),
    .cfg_addr    (i_cfg_addr),
    .cfg_wdata   (i_cfg_wdata),
    .load        (i_start),
    .attack_step (sh_attack),
    .release_step(sh_release),
    .hold_len    (sh_hold),
    .level       (sh_level),
    .loop        (sh_loop)
  );

  logic [16:0] attack_sum;
  logic        attack_sat;
  logic        release_end;
  logic        loop_wrap;

  // A zero step jumps straight to the target instead of stalling forever.
  assign attack_sum  = {1'b0, o_env_q15} + {1'b0, sh_attack};
  assign attack_sat  = (sh_attack == 16'd0) || (attack_sum >= {1'b0, sh_level});
  assign release_end = (sh_release == 16'd0) || (o_env_q15 <= sh_release);
  assign loop_wrap   = sh_loop && loop_run && !i_stop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      o_env_q15    <= 16'd0;
      hold_cnt     <= '0;
      loop_run     <= 1'b0;
      o_mod_enable <= 1'b0;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
    end else begin
      o_done <= 1'b0;
      if (i_start) begin
        state        <= ST_ATTACK;
        loop_run     <= 1'b1;
        o_mod_enable <= 1'b1;
        o_busy       <= 1'b1;
      end else if (i_stop && (state == ST_ATTACK || state == ST_HOLD)) begin
        state    <= ST_RELEASE;
        loop_run <= 1'b0;
      end else begin
        if (i_stop) loop_run <= 1'b0;
        if (i_sample_en) begin
          case (state)
            ST_ATTACK: begin
              if (attack_sat) begin
                o_env_q15 <= sh_level;
                hold_cnt  <= sh_hold;
                state     <= ST_HOLD;
              end else begin
                o_env_q15 <= attack_sum[15:0];
              end
            end
            ST_HOLD: begin
              if (hold_cnt == '0) state <= ST_RELEASE;
              else hold_cnt <= hold_cnt - HOLD_W'(1);
            end
            ST_RELEASE: begin
              if (release_end) begin
                o_env_q15 <= 16'd0;
                o_done    <= 1'b1;
                if (loop_wrap) begin
                  state <= ST_ATTACK;
                end else begin
                  state        <= ST_IDLE;
                  o_mod_enable <= 1'b0;
                  o_busy       <= 1'b0;
                end
              end else begin
                o_env_q15 <= o_env_q15 - sh_release;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_am_env_ctrl.sv
// tb/tb_am_env_ctrl.sv - self-checking bench for am_env_ctrl with a per-strobe envelope model
// Loop scenario is exercised when AM_ENV_LOOP_EN is defined.
module tb_am_env_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_sample_en = 1'b0;
  logic        i_start = 1'b0;
  logic        i_stop = 1'b0;
  logic        i_cfg_we = 1'b0;
  logic [2:0]  i_cfg_addr = 3'd0;
  logic [15:0] i_cfg_wdata = 16'd0;
  logic [15:0] o_env_q15;
  logic        o_mod_enable;
  logic        o_busy;
  logic        o_done;

  int checks = 0;
  int errors = 0;
  int exp_q[$];

  am_env_ctrl #(.HOLD_W(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_sample_en (i_sample_en),
    .i_start     (i_start),
    .i_stop      (i_stop),
    .i_cfg_we    (i_cfg_we),
    .i_cfg_addr  (i_cfg_addr),
    .i_cfg_wdata (i_cfg_wdata),
    .o_env_q15   (o_env_q15),
    .o_mod_enable(o_mod_enable),
    .o_busy      (o_busy),
    .o_done      (o_done)
  );

  always #5 clk = ~clk;

  task automatic step_clk();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    repeat (2) step_clk();
    rst = 1'b0;
    step_clk();
  endtask

  task automatic cfg_write(input logic [2:0] addr, input logic [15:0] data);
    i_cfg_we = 1'b1; i_cfg_addr = addr; i_cfg_wdata = data;
    step_clk();
    i_cfg_we = 1'b0;
  endtask

  task automatic do_strobe();
    i_sample_en = 1'b1;
    step_clk();
    i_sample_en = 1'b0;
  endtask

  task automatic pulse_start(input logic with_strobe);
    i_start = 1'b1; i_sample_en = with_strobe;
    step_clk();
    i_start = 1'b0; i_sample_en = 1'b0;
  endtask

  task automatic pulse_stop(input logic with_strobe);
    i_stop = 1'b1; i_sample_en = with_strobe;
    step_clk();
    i_stop = 1'b0; i_sample_en = 1'b0;
  endtask

  task automatic drain(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      if (!o_busy) begin ok = 1'b1; break; end
      do_strobe();
    end
  endtask

  // Envelope value after each strobe of one full run, from the profile rules.
  task automatic build_profile(input int env0, input int atk, input int lvl_raw,
                               input int hold, input int rel);
    int env, lvl;
    exp_q.delete();
    lvl = (lvl_raw > 32768) ? 32768 : lvl_raw;
    env = env0;
    forever begin
      if (atk == 0 || env + atk >= lvl) begin env = lvl; exp_q.push_back(env); break; end
      env += atk; exp_q.push_back(env);
    end
    repeat (hold + 1) exp_q.push_back(lvl);
    forever begin
      if (rel == 0 || env <= rel) begin exp_q.push_back(0); break; end
      env -= rel; exp_q.push_back(env);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if ({o_env_q15, o_mod_enable, o_busy, o_done} !== 19'd0) begin
      errors++;
      $display("FAIL reset_outputs got env=%h en=%b busy=%b done=%b exp all 0",
               o_env_q15, o_mod_enable, o_busy, o_done);
    end
    // Defaults: attack 0x100, release 0x100, hold 0, level 0x8000.
    build_profile(0, 256, 32768, 0, 256);
    pulse_start(1'b0);
    for (int i = 0; i < exp_q.size(); i++) begin
      do_strobe();
      checks++;
      if (o_env_q15 !== 16'(exp_q[i]) || o_done !== (i == exp_q.size() - 1)) begin
        errors++;
        $display("FAIL reset_defaults strobe %0d got env=%h done=%b exp env=%h", i, o_env_q15, o_done, exp_q[i]);
      end
    end
  endtask

  task automatic test_profile();
    int exp_env[9] = '{16'h2000, 16'h4000, 16'h6000, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h4000, 16'h0000};
    int done_cnt = 0;
    apply_reset();
    cfg_write(3'd3, 16'h8000);
    cfg_write(3'd0, 16'h2000);
    cfg_write(3'd2, 16'd2);
    cfg_write(3'd1, 16'h4000);
    pulse_start(1'b0);
    for (int i = 0; i < 9; i++) begin
      do_strobe();
      done_cnt += int'(o_done);
      checks++;
      if (o_env_q15 !== 16'(exp_env[i])) begin
        errors++;
        $display("FAIL profile_env strobe %0d got %h exp %h", i, o_env_q15, exp_env[i]);
      end
      checks++;
      if (o_mod_enable !== (i != 8) || o_busy !== (i != 8)) begin
        errors++;
        $display("FAIL profile_enable strobe %0d got en=%b busy=%b exp %b", i, o_mod_enable, o_busy, i != 8);
      end
      repeat (3) begin
        step_clk();
        done_cnt += int'(o_done);
      end
    end
    checks++;
    if (done_cnt != 1) begin
      errors++;
      $display("FAIL profile_done_count got %0d exp 1", done_cnt);
    end
  endtask

  task automatic test_level_clamp();
    int exp_env[3] = '{16'h3000, 16'h6000, 16'h8000};
    bit ok;
    apply_reset();
    cfg_write(3'd3, 16'h9000);
    cfg_write(3'd0, 16'h3000);
    pulse_start(1'b0);
    for (int i = 0; i < 3; i++) begin
      do_strobe();
      checks++;
      if (o_env_q15 !== 16'(exp_env[i])) begin
        errors++;
        $display("FAIL clamp_env strobe %0d got %h exp %h", i, o_env_q15, exp_env[i]);
      end
    end
    drain(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL clamp_drain got busy=%b exp 0", o_busy); end
  endtask

  task automatic test_stop_retrigger();
    int exp_env[5] = '{16'h2000, 16'h4000, 16'h4000, 16'h3000, 16'h2000};
    bit ok;
    apply_reset();
    cfg_write(3'd3, 16'h8000);
    cfg_write(3'd0, 16'h2000);
    cfg_write(3'd1, 16'h1000);
    cfg_write(3'd2, 16'd0);
    pulse_start(1'b0);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) pulse_stop(1'b1);  // coincident strobe must not step
      else do_strobe();
      checks++;
      if (o_env_q15 !== 16'(exp_env[i])) begin
        errors++;
        $display("FAIL stop_env step %0d got %h exp %h", i, o_env_q15, exp_env[i]);
      end
    end
    pulse_start(1'b1);
    checks++;
    if (o_env_q15 !== 16'h2000 || o_busy !== 1'b1) begin
      errors++;
      $display("FAIL retrigger_hold got env=%h busy=%b exp env=2000 busy=1", o_env_q15, o_busy);
    end
    do_strobe();
    checks++;
    if (o_env_q15 !== 16'h4000) begin
      errors++;
      $display("FAIL retrigger_attack got %h exp 4000", o_env_q15);
    end
    drain(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL stop_drain got busy=%b exp 0", o_busy); end
  endtask

  task automatic test_start_stop_hold();
    bit ok;
    apply_reset();
    cfg_write(3'd0, 16'h8000);
    cfg_write(3'd1, 16'h1000);
    cfg_write(3'd2, 16'd3);
    pulse_start(1'b0);
    do_strobe();
    i_start = 1'b1; i_stop = 1'b1;
    step_clk();
    i_start = 1'b0; i_stop = 1'b0;
    do_strobe();
    checks++;
    if (o_env_q15 !== 16'h8000) begin
      errors++;
      $display("FAIL start_stop_attack got %h exp 8000", o_env_q15);
    end
    pulse_stop(1'b0);
    do_strobe();
    checks++;
    if (o_env_q15 !== 16'h7000) begin
      errors++;
      $display("FAIL stop_from_hold got %h exp 7000", o_env_q15);
    end
    drain(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL start_stop_drain got busy=%b exp 0", o_busy); end
  endtask

  task automatic test_reset_mid_release();
    int exp_env[4] = '{16'h8000, 16'h8000, 16'h8000, 16'h5000};
    apply_reset();
    cfg_write(3'd0, 16'h8000);
    cfg_write(3'd1, 16'h3000);
    cfg_write(3'd2, 16'd1);
    pulse_start(1'b0);
    for (int i = 0; i < 4; i++) begin
      do_strobe();
      if (i == 0) begin
        cfg_write(3'd3, 16'h1000);
        cfg_write(3'd1, 16'h7000);
      end
      checks++;
      if (o_env_q15 !== 16'(exp_env[i])) begin
        errors++;
        $display("FAIL hold_write_env strobe %0d got %h exp %h", i, o_env_q15, exp_env[i]);
      end
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({o_env_q15, o_mod_enable, o_busy, o_done} !== 19'd0) begin
      errors++;
      $display("FAIL async_reset got env=%h en=%b busy=%b done=%b exp all 0",
               o_env_q15, o_mod_enable, o_busy, o_done);
    end
    step_clk();
    rst = 1'b0;
    step_clk();
  endtask

  task automatic test_loop();
    bit ok;
    int exp_env[4] = '{16'h4000, 16'h8000, 16'h8000, 16'h0000};
    apply_reset();
    cfg_write(3'd0, 16'h4000);
    cfg_write(3'd1, 16'h8000);
    cfg_write(3'd2, 16'd0);
    cfg_write(3'd4, 16'd1);
    pulse_start(1'b0);
`ifdef AM_ENV_LOOP_EN
    for (int c = 0; c < 2; c++) begin
      for (int i = 0; i < 4; i++) begin
        do_strobe();
        checks++;
        if (o_env_q15 !== 16'(exp_env[i]) || o_done !== (i == 3) || o_busy !== 1'b1) begin
          errors++;
          $display("FAIL loop_cycle %0d strobe %0d got env=%h done=%b busy=%b exp env=%h done=%b busy=1",
                   c, i, o_env_q15, o_done, o_busy, exp_env[i], i == 3);
        end
      end
    end
    do_strobe();
    pulse_stop(1'b0);
    do_strobe();
    checks++;
    if (o_env_q15 !== 16'h0000 || o_done !== 1'b1 || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL loop_stop got env=%h done=%b busy=%b exp env=0 done=1 busy=0", o_env_q15, o_done, o_busy);
    end
`else
    for (int i = 0; i < 4; i++) begin
      do_strobe();
      checks++;
      if (o_env_q15 !== 16'(exp_env[i]) || o_busy !== (i != 3)) begin
        errors++;
        $display("FAIL noloop strobe %0d got env=%h busy=%b exp env=%h busy=%b",
                 i, o_env_q15, o_busy, exp_env[i], i != 3);
      end
    end
`endif
    drain(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL loop_drain got busy=%b exp 0", o_busy); end
  endtask

  task automatic test_random();
    int atk, rel, lvl, hold;
    apply_reset();
    for (int it = 0; it < 20; it++) begin
      atk  = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(16'h0400, 16'h9000));
      rel  = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(16'h0400, 16'h9000));
      lvl  = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, 16'hFFFF));
      hold = int'($urandom_range(0, 5));
      cfg_write(3'd0, 16'(atk));
      cfg_write(3'd1, 16'(rel));
      cfg_write(3'd2, 16'(hold));
      cfg_write(3'd3, 16'(lvl));
      build_profile(0, atk, lvl, hold, rel);
      pulse_start(1'b0);
      for (int i = 0; i < exp_q.size(); i++) begin
        do_strobe();
        checks++;
        if (o_env_q15 !== 16'(exp_q[i]) || o_done !== (i == exp_q.size() - 1) ||
            o_busy !== (i != exp_q.size() - 1)) begin
          errors++;
          $display("FAIL random it %0d strobe %0d got env=%h done=%b busy=%b exp env=%h",
                   it, i, o_env_q15, o_done, o_busy, exp_q[i]);
        end
        repeat ($urandom_range(0, 2)) begin
          if ($urandom_range(0, 3) == 0) begin
            automatic logic [2:0] a = 3'($urandom_range(0, 6));
            cfg_write((a == 3'd4) ? 3'd7 : a, 16'($urandom));
          end else begin
            step_clk();
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_profile();
    test_level_clamp();
    test_stop_retrigger();
    test_start_stop_hold();
    test_reset_mid_release();
    test_loop();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
